// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller. Issues one instruction-memory request at a
// time from the current PC, captures the returned instruction into an output
// holding register for decode, and drives the PC register write port with
// either the sequential PC (PC + 4) or a redirect target from execute.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   now_pc          current PC from the external PC register
//   pc_we           PC register write enable
//   next_pc         value written into the PC register when pc_we = 1
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request when valid && ready
//   imem_req_addr   fetch address (always the current PC)
//   imem_resp_valid single-cycle response strobe, no backpressure
//   imem_resp_data  fetched instruction word
//   redirect_valid  branch/jump redirect strobe from execute
//   redirect_pc     redirect target (low two bits are ignored)
//   if_valid        instruction available to decode
//   if_ready        decode accepts the instruction when if_valid && if_ready
//   if_pc           PC of the presented instruction
//   if_instr        presented instruction
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] now_pc,
  output logic                  pc_we,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    KILL = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  capture;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] redirect_target;

  // Sequential PC wraps naturally at 2^DATA_WIDTH.
  assign pc_plus4 = now_pc + {{(DATA_WIDTH-3){1'b0}}, 3'b100};

  // Redirect targets are forced to word alignment by masking the low bits.
  assign redirect_target = redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  // The fetch address is always the live PC; memory only samples it on accept,
  // so it is allowed to move in the cycle following a redirect.
  assign imem_req_addr = now_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. A redirect overrides any sequential PC
  // update and steers the FSM either straight back to REQ (nothing in flight)
  // or to KILL (a request is in flight whose response must be dropped).
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    pc_we          = 1'b0;
    next_pc        = now_pc;
    capture        = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        imem_req_valid = 1'b1;
        if (redirect_valid) begin
          state_d = imem_req_ready ? KILL : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_resp_valid ? REQ : KILL;
        end else if (imem_resp_valid) begin
          capture = 1'b1;
          pc_we   = 1'b1;
          next_pc = pc_plus4;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid || if_ready) begin
          state_d = REQ;
        end
      end

      KILL: begin
        if (imem_resp_valid) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_we   = 1'b1;
      next_pc = redirect_target;
    end

    // Redirect is combinational to pc_we, so it has to be masked while the
    // block is held in reset.
    if (!rst_n) begin
      pc_we          = 1'b0;
      next_pc        = now_pc;
      imem_req_valid = 1'b0;
    end
  end

  // Decode-side holding register. The captured PC is the PC of the fetch,
  // which is still now_pc in the response cycle because the PC register only
  // advances on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (capture) begin
      if_valid <= 1'b1;
      if_pc    <= now_pc;
      if_instr <= imem_resp_data;
    end else if (redirect_valid || (state_q == HOLD && if_ready)) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Self-checking bench for fetch_ctrl. The bench owns the PC register (fed by
// pc_we/next_pc) and plays both instruction memory and decode. Every
// instruction the bench expects decode to receive is pushed to a scoreboard
// when its memory response is driven, and popped/compared on the decode
// handshake. Per-cycle control outputs are compared against constants.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] now_pc;
  logic          pc_we;
  logic [DW-1:0] next_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_pc;
  logic [DW-1:0] if_instr;

  logic          pc_load;
  logic [DW-1:0] pc_load_val;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_t;

  fetch_t sb_q[$];

  int checks;
  int errors;

  fetch_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .now_pc          (now_pc),
    .pc_we           (pc_we),
    .next_pc         (next_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register: a bench load wins over the DUT write port.
  always @(posedge clk) begin
    if (pc_load) begin
      now_pc <= pc_load_val;
    end else if (pc_we) begin
      now_pc <= next_pc;
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive all inputs at the falling edge, let combinational
  // outputs settle, then retire a scoreboard entry on a decode handshake.
  task automatic applyStimulus(input logic ready, input logic resp_v,
                               input logic [DW-1:0] resp_d, input logic redir,
                               input logic [DW-1:0] redir_pc, input logic ifr);
    fetch_t exp;
    @(negedge clk);
    imem_req_ready  = ready;
    imem_resp_valid = resp_v;
    imem_resp_data  = resp_d;
    redirect_valid  = redir;
    redirect_pc     = redir_pc;
    if_ready        = ifr;
    #1;
    if (if_valid && if_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_if", {31'b0, if_valid}, '0);
      end else begin
        exp = sb_q.pop_front();
        checkOutput("sb_if_pc", if_pc, exp.pc);
        checkOutput("sb_if_instr", if_instr, exp.instr);
      end
    end
  endtask

  task automatic pushExpected(input logic [DW-1:0] pc, input logic [DW-1:0] instr);
    sb_q.push_back('{pc: pc, instr: instr});
  endtask

  // Hold reset for two cycles while loading the PC register, with a redirect
  // and response present to show they cannot leak through, then release.
  task automatic doReset(input logic [DW-1:0] pc_val);
    @(negedge clk);
    rst_n           = 1'b0;
    pc_load         = 1'b1;
    pc_load_val     = pc_val;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0077;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0055;
    if_ready        = 1'b1;
    #1;
    checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    checkOutput("rst_pc_we", {31'b0, pc_we}, 32'd0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    pc_load         = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    pc_load         = 1'b0;
    pc_load_val     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if_ready        = 1'b0;

    // Basic fetch from PC 0 with immediate acceptance by decode.
    doReset(32'h0000_0000);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("f0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("f0_req_addr", imem_req_addr, 32'h0);
    checkOutput("f0_req_pc_we", {31'b0, pc_we}, 32'd0);
    pushExpected(32'h0, 32'h0000_0013);
    applyStimulus(0, 1, 32'h0000_0013, 0, 0, 1);
    checkOutput("f0_resp_pc_we", {31'b0, pc_we}, 32'd1);
    checkOutput("f0_resp_next_pc", next_pc, 32'h4);
    checkOutput("f0_resp_if_valid", {31'b0, if_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("f0_hold_if_valid", {31'b0, if_valid}, 32'd1);
    checkOutput("f0_hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("f1_if_valid_clr", {31'b0, if_valid}, 32'd0);
    checkOutput("f1_req_addr", imem_req_addr, 32'h4);

    // Decode stalls for five cycles: output must hold and no new request.
    pushExpected(32'h4, 32'hAABB_CCDD);
    applyStimulus(1, 1, 32'hAABB_CCDD, 0, 0, 0);
    checkOutput("f1_next_pc", next_pc, 32'h8);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("stall_if_valid", {31'b0, if_valid}, 32'd1);
      checkOutput("stall_if_pc", if_pc, 32'h4);
      checkOutput("stall_if_instr", if_instr, 32'hAABB_CCDD);
      checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      checkOutput("stall_pc_we", {31'b0, pc_we}, 32'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("f2_req_addr", imem_req_addr, 32'h8);

    // Redirect to 0x103 while waiting: aligned target, stale response dropped.
    applyStimulus(0, 0, 0, 1, 32'h0000_0103, 1);
    checkOutput("rw_pc_we", {31'b0, pc_we}, 32'd1);
    checkOutput("rw_next_pc", next_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("kill_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("kill_pc_we", {31'b0, pc_we}, 32'd0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    checkOutput("kill_drop_pc_we", {31'b0, pc_we}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("kill_drop_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rw_req_addr", imem_req_addr, 32'h100);
    pushExpected(32'h100, 32'h1111_1111);
    applyStimulus(0, 1, 32'h1111_1111, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("f3_req_addr", imem_req_addr, 32'h104);

    // Redirect coincident with the response: response discarded.
    applyStimulus(0, 1, 32'h2222_2222, 1, 32'h0000_0200, 1);
    checkOutput("rr_pc_we", {31'b0, pc_we}, 32'd1);
    checkOutput("rr_next_pc", next_pc, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rr_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rr_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("rr_req_addr", imem_req_addr, 32'h200);

    // Redirect in REQ without accept, then with accept, then inside KILL.
    applyStimulus(0, 0, 0, 1, 32'h0000_0300, 1);
    checkOutput("rq_next_pc", next_pc, 32'h300);
    applyStimulus(1, 0, 0, 1, 32'h0000_040C, 1);
    checkOutput("rq_addr_moved", imem_req_addr, 32'h300);
    checkOutput("rqa_next_pc", next_pc, 32'h40C);
    applyStimulus(0, 0, 0, 1, 32'h0000_0500, 1);
    checkOutput("rk_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rk_next_pc", next_pc, 32'h500);
    applyStimulus(0, 1, 32'h3333_3333, 0, 0, 1);
    checkOutput("rk_drop_pc_we", {31'b0, pc_we}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("rk_req_addr", imem_req_addr, 32'h500);

    // Redirect while an instruction is held for decode.
    applyStimulus(0, 1, 32'h0000_0022, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0600, 0);
    checkOutput("rh_if_pc", if_pc, 32'h500);
    checkOutput("rh_if_instr", if_instr, 32'h22);
    checkOutput("rh_next_pc", next_pc, 32'h600);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rh_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rh_req_addr", imem_req_addr, 32'h600);

    // PC wrap at the top of the address space.
    doReset(32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    pushExpected(32'hFFFF_FFFC, 32'h0000_0033);
    applyStimulus(0, 1, 32'h0000_0033, 0, 0, 1);
    checkOutput("wrap_next_pc", next_pc, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("wrap_req_addr2", imem_req_addr, 32'h0);

    // Reset while waiting; the late response must be ignored.
    applyStimulus(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0099;
    #1;
    checkOutput("rw_rst_if_pc", if_pc, 32'h0);
    checkOutput("rw_rst_if_instr", if_instr, 32'h0);
    checkOutput("rw_rst_pc_we", {31'b0, pc_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("late_resp_pc_we", {31'b0, pc_we}, 32'd0);
    checkOutput("late_resp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("late_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("restart_req_addr", imem_req_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("late_if_valid2", {31'b0, if_valid}, 32'd0);

    checkOutput("sb_left", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
